// File: rtl/adc_capture_gate.sv
// Windowed capture of a free-running ADC AXI4-Stream into a readout-buffer stream
// through a 2-entry skid buffer. Optional feature macro: ADC_CAPTURE_TLAST_EN (adds buf_tlast).
module adc_capture_gate #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  capture_i,
  input  logic [LEN_WIDTH-1:0]  capture_len_i,
  input  logic [DATA_WIDTH-1:0] adc_tdata,
  input  logic                  adc_tvalid,
  output logic                  adc_tready,
  output logic [DATA_WIDTH-1:0] buf_tdata,
  output logic                  buf_tvalid,
`ifdef ADC_CAPTURE_TLAST_EN
  output logic                  buf_tlast,
`endif
  input  logic                  buf_tready,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  overflow_q, overflow_d;
  logic                  adc_tready_q;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
`ifdef ADC_CAPTURE_TLAST_EN
  logic                  last0_q, last0_d, last1_q, last1_d;
`endif

  logic       adc_hs;
  logic       pop;
  logic       win_beat;
  logic       final_beat;
  logic [1:0] count_pop;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    count_d     = count_q;
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
`ifdef ADC_CAPTURE_TLAST_EN
    last0_d     = last0_q;
    last1_d     = last1_q;
`endif
    adc_hs     = adc_tvalid & adc_tready_q;
    pop        = (count_q != 2'd0) & buf_tready;
    win_beat   = (state_q == ST_CAPTURE) & adc_hs;
    final_beat = win_beat & (remaining_q == LEN_WIDTH'(1));
    count_pop  = count_q - {1'b0, pop};

    // Entry 0 is always the head; a pop shifts entry 1 down before any push lands.
    if (pop) begin
      ent0_d = ent1_q;
`ifdef ADC_CAPTURE_TLAST_EN
      last0_d = last1_q;
`endif
    end
    count_d = count_pop;

    unique case (state_q)
      ST_IDLE: begin
        if (capture_i && (capture_len_i != '0)) begin
          remaining_d = capture_len_i;
          overflow_d  = 1'b0;
          state_d     = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (win_beat) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (count_pop != 2'd2) begin
            count_d = count_pop + 2'd1;
            if (count_pop == 2'd0) begin
              ent0_d = adc_tdata;
`ifdef ADC_CAPTURE_TLAST_EN
              last0_d = final_beat;
`endif
            end else begin
              ent1_d = adc_tdata;
`ifdef ADC_CAPTURE_TLAST_EN
              last1_d = final_beat;
`endif
            end
          end else begin
            // Full with no pop: drop the beat, but the final beat replaces the newest entry.
            overflow_d = 1'b1;
            if (final_beat) begin
              ent1_d = adc_tdata;
`ifdef ADC_CAPTURE_TLAST_EN
              last1_d = 1'b1;
`endif
            end
          end
          if (final_beat) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (count_q == 2'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      overflow_q   <= 1'b0;
      adc_tready_q <= 1'b0;
      count_q      <= '0;
      ent0_q       <= '0;
      ent1_q       <= '0;
`ifdef ADC_CAPTURE_TLAST_EN
      last0_q      <= 1'b0;
      last1_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      overflow_q   <= overflow_d;
      adc_tready_q <= 1'b1;
      count_q      <= count_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
`ifdef ADC_CAPTURE_TLAST_EN
      last0_q      <= last0_d;
      last1_q      <= last1_d;
`endif
    end
  end

  assign adc_tready = adc_tready_q;
  assign buf_tvalid = (count_q != 2'd0);
  assign buf_tdata  = ent0_q;
`ifdef ADC_CAPTURE_TLAST_EN
  assign buf_tlast  = last0_q;
`endif
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DRAIN) && (count_q == 2'd0);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_adc_capture_gate.sv
// Scoreboard bench for adc_capture_gate: stimulus pushes expected beats and done cycles,
// a negedge monitor pops and compares whenever the DUT hands over a beat or pulses done.
module tb_adc_capture_gate;
  localparam int unsigned DW = 128;
  localparam int unsigned LW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          capture_i = 1'b0;
  logic [LW-1:0] capture_len_i = '0;
  logic [DW-1:0] adc_tdata = '0;
  logic          adc_tvalid = 1'b0;
  logic          adc_tready;
  logic [DW-1:0] buf_tdata;
  logic          buf_tvalid;
  logic          buf_tready = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;
`ifdef ADC_CAPTURE_TLAST_EN
  logic          buf_tlast;
`endif

  adc_capture_gate #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .capture_i    (capture_i),
    .capture_len_i(capture_len_i),
    .adc_tdata    (adc_tdata),
    .adc_tvalid   (adc_tvalid),
    .adc_tready   (adc_tready),
    .buf_tdata    (buf_tdata),
    .buf_tvalid   (buf_tvalid),
`ifdef ADC_CAPTURE_TLAST_EN
    .buf_tlast    (buf_tlast),
`endif
    .buf_tready   (buf_tready),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_done_q[$];   // -1 means "one cycle after the last output handshake"
  int    n_tests = 0;
  int    n_fail  = 0;
  int    last_hs_cyc = -100;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    capture_i = 1'b0;
    adc_tdata = adc_tdata + 1;
  endtask

  task automatic request(input int len, output int r);
    capture_i     = 1'b1;
    capture_len_i = LW'(len);
    r             = cyc;
  endtask

  task automatic check_empty(input string name);
    check({name, "_beats_left"}, exp_q.size(), 0);
    check({name, "_done_left"}, exp_done_q.size(), 0);
  endtask

  // Monitor
  always @(negedge aclk) begin
    beat_t eb;
    int    ed;
    if (buf_tvalid && buf_tready) begin
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h, required no beat (cycle %0d)", buf_tdata, cyc);
      end else begin
        eb = exp_q.pop_front();
        check("beat_data", buf_tdata, eb.data);
`ifdef ADC_CAPTURE_TLAST_EN
        check("beat_last", buf_tlast, eb.last);
`endif
      end
    end
    if (done_o) begin
      if (exp_done_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        ed = exp_done_q.pop_front();
        if (ed < 0) ed = last_hs_cyc + 1;
        check("done_cycle", cyc, ed);
      end
    end
  end

  int unsigned rdy_pat[16] = '{1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    int r;
    int r2;

    // Reset state
    aresetn    = 1'b0;
    adc_tvalid = 1'b1;
    tick();
    tick();
    check("rst_buf_tvalid", buf_tvalid, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_adc_tready", adc_tready, 0);
    aresetn = 1'b1;
    tick();
    check("adc_tready_after_rst", adc_tready, 1);

    // Basic window, len 8
    buf_tready = 1'b1;
    adc_tdata  = 'h10;
    request(8, r);
    for (int k = 1; k <= 8; k++) push_beat(DW'('h10 + k), k == 8);
    exp_done_q.push_back(r + 10);
    tick();
    check("basic_busy", busy_o, 1);
    repeat (11) tick();
    check("basic_overflow", overflow_o, 0);
    check("basic_busy_end", busy_o, 0);
    check_empty("basic");

    // Zero length request is ignored
    request(0, r);
    tick();
    check("zero_busy", busy_o, 0);
    repeat (4) tick();
    check("zero_busy_end", busy_o, 0);
    check_empty("zero");

    // Full backpressure, len 5
    buf_tready = 1'b0;
    adc_tdata  = 'h40;
    request(5, r);
    push_beat(DW'('h41), 1'b0);
    push_beat(DW'('h45), 1'b1);
    repeat (3) tick();
    check("bp_hold_data", buf_tdata, 'h41);
    repeat (3) tick();
    check("bp_overflow", overflow_o, 1);
    check("bp_tvalid", buf_tvalid, 1);
    check("bp_head", buf_tdata, 'h41);
    check("bp_busy", busy_o, 1);
    buf_tready = 1'b1;
    exp_done_q.push_back(r + 8);
    repeat (4) tick();
    check("bp_overflow_sticky", overflow_o, 1);
    check("bp_busy_end", busy_o, 0);
    check_empty("bp");

    // Requests while busy and on the done cycle are ignored
    adc_tdata = 'h80;
    request(3, r);
    for (int k = 1; k <= 3; k++) push_beat(DW'('h80 + k), k == 3);
    exp_done_q.push_back(r + 5);
    tick();
    check("busy_ovf_cleared", overflow_o, 0);
    tick();
    request(5, r2);
    repeat (3) tick();
    check("busy_done_cycle", done_o, 1);
    request(5, r2);
    tick();
    request(2, r2);
    push_beat(DW'('h87), 1'b0);
    push_beat(DW'('h88), 1'b1);
    exp_done_q.push_back(r2 + 4);
    repeat (6) tick();
    check("busy_end", busy_o, 0);
    check_empty("busy");

    // Reset mid-window after 3 of 8 beats
    adc_tdata = 'hC0;
    request(8, r);
    for (int k = 1; k <= 3; k++) push_beat(DW'('hC0 + k), 1'b0);
    repeat (4) tick();
    aresetn = 1'b0;
    tick();
    check("mid_rst_tvalid", buf_tvalid, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_overflow", overflow_o, 0);
    check("mid_rst_adc_tready", adc_tready, 0);
    aresetn = 1'b1;
    tick();
    adc_tdata = 'hD0;
    request(4, r2);
    for (int k = 1; k <= 4; k++) push_beat(DW'('hD0 + k), k == 4);
    exp_done_q.push_back(r2 + 6);
    repeat (8) tick();
    check("mid_rst_busy_end", busy_o, 0);
    check_empty("mid_rst");

    // Gapped input with irregular backpressure, len 6
    adc_tdata = 'hE0;
    request(6, r);
    for (int k = 1; k <= 6; k++) push_beat(DW'('hE0 + 2 * k - 1), k == 6);
    exp_done_q.push_back(-1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      adc_tvalid = (k % 2) == 1;
      buf_tready = rdy_pat[k-1] != 0;
    end
    check("gap_overflow", overflow_o, 0);
    check("gap_busy_end", busy_o, 0);
    check_empty("gap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
